div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage, executing DIV and DIVU. It consumes the operand pair produced by ID operand generation (operand_1 = rs value as dividend, operand_2 = rt value as divisor) after the ID/EX register. It computes the result with a radix-2 restoring algorithm, one quotient bit per cycle. While it is computing it holds the pipeline through a stall request and returns quotient/remainder for the HI/LO write.

---
 rtl/div_unit.sv | 116 +++++++++++
 tb/tb_div_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces one quotient bit per cycle and stalls the pipeline while it works.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    output logic                  stall_req,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [2*DATA_WIDTH-1:0] work_reg;
    logic [DATA_WIDTH-1:0]   divisor_reg;
    logic                    quo_neg_reg;
    logic                    rem_neg_reg;
    logic [DATA_WIDTH-1:0]   hi_reg;
    logic [DATA_WIDTH-1:0]   lo_reg;

    logic                    sign1;
    logic                    sign2;
    logic [DATA_WIDTH-1:0]   abs_dividend;
    logic [DATA_WIDTH-1:0]   abs_divisor;
    logic [DATA_WIDTH:0]     trial_rem;
    logic [DATA_WIDTH:0]     diff;
    logic                    fits;
    logic [DATA_WIDTH-1:0]   rem_next;
    logic [DATA_WIDTH-1:0]   quo_next;
    logic [DATA_WIDTH-1:0]   lo_next;
    logic [DATA_WIDTH-1:0]   hi_next;

    assign sign1        = is_signed & operand_1[DATA_WIDTH-1];
    assign sign2        = is_signed & operand_2[DATA_WIDTH-1];
    assign abs_dividend = sign1 ? (~operand_1 + ONE) : operand_1;
    assign abs_divisor  = sign2 ? (~operand_2 + ONE) : operand_2;

    // The shifted remainder keeps its carry-out bit so divisors above 2^31
    // still compare correctly in the 33-bit trial subtraction.
    assign trial_rem = work_reg[2*DATA_WIDTH-1:DATA_WIDTH-1];
    assign diff      = trial_rem - {1'b0, divisor_reg};
    assign fits      = ~diff[DATA_WIDTH];
    assign rem_next  = fits ? diff[DATA_WIDTH-1:0] : trial_rem[DATA_WIDTH-1:0];
    assign quo_next  = {work_reg[DATA_WIDTH-2:0], fits};
    assign lo_next   = quo_neg_reg ? (~quo_next + ONE) : quo_next;
    assign hi_next   = rem_neg_reg ? (~rem_next + ONE) : rem_next;

    assign done      = (state_reg == ST_DONE);
    assign stall_req = ((state_reg == ST_IDLE) & start & ~flush) | (state_reg == ST_BUSY);
    assign hi        = hi_reg;
    assign lo        = lo_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            work_reg    <= '0;
            divisor_reg <= '0;
            quo_neg_reg <= 1'b0;
            rem_neg_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else if (flush) begin
            // Abandon any division; the previous HI/LO result stays visible.
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (operand_2 == '0) begin
                            lo_reg    <= '1;
                            hi_reg    <= operand_1;
                            state_reg <= ST_DONE;
                        end else begin
                            divisor_reg <= abs_divisor;
                            quo_neg_reg <= sign1 ^ sign2;
                            rem_neg_reg <= sign1;
                            work_reg    <= {{DATA_WIDTH{1'b0}}, abs_dividend};
                            count_reg   <= '0;
                            state_reg   <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    work_reg  <= {rem_next, quo_next};
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_CNT) begin
                        lo_reg    <= lo_next;
                        hi_reg    <= hi_next;
                        state_reg <= ST_DONE;
                    end
                end
                // EX still holds start for the finished instruction, so ignore it here.
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: latency, signed/unsigned results,
// divide-by-zero, flush, back-to-back requests and asynchronous reset.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        start;
    logic        is_signed;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start),
        .is_signed (is_signed),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1);
    end

    // Issues one request in cycle T and holds start until done is seen.
    // lat is the offset of the done cycle from T (-1 if it never came).
    task automatic issue_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                             output int lat, output int stalls);
        lat    = -1;
        stalls = 0;
        @(posedge clk); #1;
        start = 1'b1; is_signed = sgn; operand_1 = a; operand_2 = b;
        @(negedge clk);
        if (stall_req) stalls++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (done) begin
                lat = k;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; start = 1'b0; is_signed = 1'b0;
        operand_1 = 32'd0; operand_2 = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %0b, required 0", done); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b, required 0", stall_req); end
        n_checks++; if (hi !== 32'd0)       begin n_fail++; $display("FAIL reset_hi: got %h, required 0", hi); end
        n_checks++; if (lo !== 32'd0)       begin n_fail++; $display("FAIL reset_lo: got %h, required 0", lo); end
        rst = 1'b0;
        $display("reset: done=%0b stall_req=%0b hi=%h lo=%h", done, stall_req, hi, lo);
    endtask

    task automatic test_divu_basic();
        int lat, stalls;
        issue_div(32'd100, 32'd7, 1'b0, lat, stalls);
        $display("DIVU 100/7: lat=%0d stalls=%0d lo=%h hi=%h", lat, stalls, lo, hi);
        n_checks++; if (lat !== 33)      begin n_fail++; $display("FAIL divu_latency: got %0d, required 33", lat); end
        n_checks++; if (stalls !== 33)   begin n_fail++; $display("FAIL divu_stall_cycles: got %0d, required 33", stalls); end
        n_checks++; if (lo !== 32'd14)   begin n_fail++; $display("FAIL divu_lo: got %h, required %h", lo, 32'd14); end
        n_checks++; if (hi !== 32'd2)    begin n_fail++; $display("FAIL divu_hi: got %h, required %h", hi, 32'd2); end
    endtask

    task automatic test_div_signed();
        int lat, stalls;
        issue_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, stalls);
        $display("DIV -7/2: lo=%h hi=%h", lo, hi);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2_lo: got %h, required fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_m7_2_hi: got %h, required ffffffff", hi); end
        issue_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat, stalls);
        $display("DIV 7/-2: lo=%h hi=%h", lo, hi);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2_lo: got %h, required fffffffd", lo); end
        n_checks++; if (hi !== 32'd1)         begin n_fail++; $display("FAIL div_7_m2_hi: got %h, required 00000001", hi); end
    endtask

    task automatic test_boundary();
        int lat, stalls;
        issue_div(32'hFFFF_FFFF, 32'd1, 1'b0, lat, stalls);
        $display("DIVU ffffffff/1: lo=%h hi=%h", lo, hi);
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_max_lo: got %h, required ffffffff", lo); end
        n_checks++; if (hi !== 32'd0)         begin n_fail++; $display("FAIL divu_max_hi: got %h, required 00000000", hi); end
        issue_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, stalls);
        $display("DIV 80000000/ffffffff: lo=%h hi=%h", lo, hi);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h, required 80000000", lo); end
        n_checks++; if (hi !== 32'd0)         begin n_fail++; $display("FAIL div_ovf_hi: got %h, required 00000000", hi); end
        // Divisor above 2^31: needs the carry bit of the shifted remainder.
        issue_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, lat, stalls);
        $display("DIVU ffffffff/80000001: lo=%h hi=%h", lo, hi);
        n_checks++; if (lo !== 32'd1)         begin n_fail++; $display("FAIL divu_bigdiv_lo: got %h, required 00000001", lo); end
        n_checks++; if (hi !== 32'h7FFF_FFFE) begin n_fail++; $display("FAIL divu_bigdiv_hi: got %h, required 7ffffffe", hi); end
    endtask

    task automatic test_div_zero();
        int lat, stalls;
        issue_div(32'd5, 32'd0, 1'b0, lat, stalls);
        $display("DIVU 5/0: lat=%0d stalls=%0d lo=%h hi=%h", lat, stalls, lo, hi);
        n_checks++; if (lat !== 1)            begin n_fail++; $display("FAIL div0_latency: got %0d, required 1", lat); end
        n_checks++; if (stalls !== 1)         begin n_fail++; $display("FAIL div0_stall_cycles: got %0d, required 1", stalls); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h, required ffffffff", lo); end
        n_checks++; if (hi !== 32'd5)         begin n_fail++; $display("FAIL div0_hi: got %h, required 00000005", hi); end
    endtask

    task automatic test_flush();
        int lat, stalls, dones;
        issue_div(32'd100, 32'd7, 1'b0, lat, stalls);   // hi/lo = 2/14
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;                                     // cycle T+10
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;                       // cycle T+11
        @(negedge clk);
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b, required 0", stall_req); end
        dones = 0;
        if (done) dones++;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        $display("flush: dones=%0d lo=%h hi=%h", dones, lo, hi);
        n_checks++; if (dones !== 0)     begin n_fail++; $display("FAIL flush_no_done: got %0d pulses, required 0", dones); end
        n_checks++; if (lo !== 32'd14)   begin n_fail++; $display("FAIL flush_lo_hold: got %h, required 0000000e", lo); end
        n_checks++; if (hi !== 32'd2)    begin n_fail++; $display("FAIL flush_hi_hold: got %h, required 00000002", hi); end
    endtask

    task automatic test_back_to_back();
        int dones, first_lat, second_lat;
        dones = 0; first_lat = -1; second_lat = -1;
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7;
        @(negedge clk);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first_lat < 0) first_lat = k;
            end
        end
        @(posedge clk); #1;                               // cycle T+34, start still high
        operand_1 = 32'd9; operand_2 = 32'd3;
        @(negedge clk);
        if (done) dones++;
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_stall: got %0b, required 1", stall_req); end
        n_checks++; if (lo !== 32'd14)      begin n_fail++; $display("FAIL b2b_first_lo: got %h, required 0000000e", lo); end
        for (int k = 35; k <= 80; k++) begin
            @(negedge clk);
            if (done) begin
                second_lat = k;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        $display("back-to-back: first_lat=%0d dones=%0d second_lat=%0d lo=%h hi=%h",
                 first_lat, dones, second_lat, lo, hi);
        n_checks++; if (first_lat !== 33)  begin n_fail++; $display("FAIL b2b_first_latency: got %0d, required 33", first_lat); end
        n_checks++; if (dones !== 1)       begin n_fail++; $display("FAIL b2b_single_done: got %0d pulses, required 1", dones); end
        n_checks++; if (second_lat !== 67) begin n_fail++; $display("FAIL b2b_second_latency: got %0d, required 67", second_lat); end
        n_checks++; if (lo !== 32'd3)      begin n_fail++; $display("FAIL b2b_lo: got %h, required 00000003", lo); end
        n_checks++; if (hi !== 32'd0)      begin n_fail++; $display("FAIL b2b_hi: got %h, required 00000000", hi); end
    endtask

    task automatic test_async_reset();
        int dones;
        dones = 0;
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7;
        repeat (6) @(negedge clk);
        #2;                                               // mid low phase, away from any edge
        rst = 1'b1; start = 1'b0;
        #1;
        $display("async reset: done=%0b stall_req=%0b lo=%h hi=%h", done, stall_req, lo, hi);
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL arst_done: got %0b, required 0", done); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL arst_stall: got %0b, required 0", stall_req); end
        n_checks++; if (lo !== 32'd0)       begin n_fail++; $display("FAIL arst_lo: got %h, required 00000000", lo); end
        n_checks++; if (hi !== 32'd0)       begin n_fail++; $display("FAIL arst_hi: got %h, required 00000000", hi); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL arst_no_done: got %0d pulses, required 0", dones); end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_boundary();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
